// File: rtl/key_ctrl.sv
// Front-panel key front end: synchronises and debounces three active-low buttons,
// toggles stop/play and emits single-cycle inc/dec pulses with auto-repeat.
module key_ctrl #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 40_000_000,
  parameter int REPEAT_CYCLES     = 5_000_000
) (
  input  logic sclk,
  input  logic nrst,
  input  logic key_mode,
  input  logic key_inc,
  input  logic key_dec,
  output logic state,
  output logic inc_sig,
  output logic dec_sig
);

  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  // Bit 0 = mode, bit 1 = inc, bit 2 = dec throughout.
  logic [2:0]      raw_keys;
  logic [2:0]      sync_a;
  logic [2:0]      sync_b;
  logic [2:0]      deb;
  logic [2:0]      deb_prev;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt [3];

  logic [1:0]        rpt_state [2];
  logic [1:0]        rpt_next  [2];
  logic [HOLD_W-1:0] hold_cnt  [2];
  logic [HOLD_W-1:0] hold_next [2];
  logic [1:0]        req;

  assign raw_keys = {key_dec, key_inc, key_mode};
  assign press    = deb_prev & ~deb;

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      sync_a   <= 3'b111;
      sync_b   <= 3'b111;
      deb      <= 3'b111;
      deb_prev <= 3'b111;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync_a   <= raw_keys;
      sync_b   <= sync_a;
      deb_prev <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] != deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            deb[i]    <= sync_b[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A release (debounced level back to 1) wins over a due repeat in the same cycle.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      rpt_next[j]  = rpt_state[j];
      hold_next[j] = hold_cnt[j];
      req[j]       = 1'b0;
      case (rpt_state[j])
        IDLE: begin
          if (press[j+1]) begin
            rpt_next[j]  = HOLD;
            hold_next[j] = '0;
            req[j]       = 1'b1;
          end
        end
        HOLD: begin
          if (deb[j+1]) begin
            rpt_next[j]  = IDLE;
            hold_next[j] = '0;
          end else if (hold_cnt[j] == LONG_LAST) begin
            rpt_next[j]  = REPEAT;
            hold_next[j] = '0;
            req[j]       = 1'b1;
          end else begin
            hold_next[j] = hold_cnt[j] + 1'b1;
          end
        end
        REPEAT: begin
          if (deb[j+1]) begin
            rpt_next[j]  = IDLE;
            hold_next[j] = '0;
          end else if (hold_cnt[j] == RPT_LAST) begin
            hold_next[j] = '0;
            req[j]       = 1'b1;
          end else begin
            hold_next[j] = hold_cnt[j] + 1'b1;
          end
        end
        default: begin
          rpt_next[j]  = IDLE;
          hold_next[j] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      for (int j = 0; j < 2; j++) begin
        rpt_state[j] <= IDLE;
        hold_cnt[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        rpt_state[j] <= rpt_next[j];
        hold_cnt[j]  <= hold_next[j];
      end
    end
  end

  // Coincident inc/dec requests cancel each other; the FSMs carry on regardless.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      state   <= 1'b0;
      inc_sig <= 1'b0;
      dec_sig <= 1'b0;
    end else begin
      state   <= state ^ press[0];
      inc_sig <= req[0] & ~req[1];
      dec_sig <= req[1] & ~req[0];
    end
  end

endmodule
